// File: rtl/rv32_instr_encoder.sv
// rv32_instr_encoder: packs RV32I fields into instruction words behind a 2-entry FIFO.
module rv32_instr_encoder #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [2:0]       funct3,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [6:0]       funct7,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic             err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);
  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       occ;
  logic             acc, illegal, push, pop;
  logic [WIDTH-1:0] word;
  assign in_ready  = occ != 2'd2;
  assign out_valid = occ != 2'd0;
  assign out_instr = mem[rd_ptr];
  assign acc       = in_valid && in_ready;
  // B and J offsets must be halfword aligned
  assign illegal   = fmt[2] && fmt[1] || opcode[1:0] != 2'b11 ||
                     (fmt == 3'd3 || fmt == 3'd5) && imm[0];
  assign push      = acc && !illegal;
  assign pop       = out_valid && out_ready;
  always_comb begin
    word = fmt == 3'd0 ? {funct7, rs2, rs1, funct3, rd, opcode} :
           fmt == 3'd1 ? {imm[11:0], rs1, funct3, rd, opcode} :
           fmt == 3'd2 ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
           fmt == 3'd3 ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode} :
           fmt == 3'd4 ? {imm[31:12], rd, opcode} :
                         {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
  end
  always_ff @(posedge clk)
    if (push && !rst) mem[wr_ptr] <= word;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occ       <= 2'd0;
      err       <= 1'b0;
      enc_count <= '0;
      err_count <= '0;
    end else begin
      wr_ptr    <= wr_ptr ^ push;
      rd_ptr    <= rd_ptr ^ pop;
      occ       <= occ + {1'b0, push} - {1'b0, pop};
      err       <= acc && illegal;
      enc_count <= enc_count + CNT_W'(push);
      err_count <= err_count + CNT_W'(acc && illegal);
    end
  end
endmodule

// File: tb/tb_rv32_instr_encoder.sv
// tb_rv32_instr_encoder: directed and random checks against a queue-based reference model.
module tb_rv32_instr_encoder;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic        in_ready, out_valid, err;
  logic [2:0]  fmt = 0, funct3 = 0;
  logic [6:0]  opcode = 7'h33, funct7 = 0;
  logic [4:0]  rd = 0, rs1 = 0, rs2 = 0;
  logic [31:0] imm = 0, out_instr;
  logic [15:0] enc_count, err_count;
  int checks = 0, errors = 0;
  logic [31:0] q[$];
  logic [15:0] m_enc = 0, m_err = 0;
  logic        err_exp = 0, chk_en = 0, last_acc = 0;

  rv32_instr_encoder dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .err(err), .enc_count(enc_count), .err_count(err_count));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_enc(int unsigned f, int unsigned op, int unsigned d,
      int unsigned f3, int unsigned s1, int unsigned s2, int unsigned f7, int unsigned im);
    int unsigned base = op | (f3 << 12) | (s1 << 15);
    case (f)
      0: return base | (d << 7) | (s2 << 20) | (f7 << 25);
      1: return base | (d << 7) | ((im % 4096) << 20);
      2: return base | (s2 << 20) | ((im % 32) << 7) | (((im / 32) % 128) << 25);
      3: return base | (s2 << 20) | (((im / 4096) % 2) << 31) | (((im / 32) % 64) << 25)
                     | (((im / 2) % 16) << 8) | (((im / 2048) % 2) << 7);
      4: return op | (d << 7) | (im / 4096 * 4096);
      default: return op | (d << 7) | (((im / 1048576) % 2) << 31) | (((im / 2) % 1024) << 21)
                     | (((im / 2048) % 2) << 20) | (((im / 4096) % 256) << 12);
    endcase
  endfunction

  function automatic bit ref_legal(int unsigned f, int unsigned op, int unsigned im);
    return f <= 5 && op % 4 == 3 && !((f == 3 || f == 5) && im % 2 == 1);
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    bit pop, lg;
    logic [31:0] w;
    @(negedge clk);
    if (chk_en) begin
      check("in_ready", in_ready, q.size() < 2);
      check("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) check("out_instr", out_instr, q[0]);
      check("err", err, err_exp);
      check("enc_count", enc_count, m_enc);
      check("err_count", err_count, m_err);
    end
    last_acc = in_valid && q.size() < 2 && !rst;
    pop = q.size() != 0 && out_ready;
    lg = ref_legal(fmt, opcode, imm);
    w = ref_enc(fmt, opcode, rd, funct3, rs1, rs2, funct7, imm);
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_enc = 0;
      m_err = 0;
      err_exp = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (last_acc && lg) begin
        q.push_back(w);
        m_enc++;
      end
      err_exp = last_acc && !lg;
      if (err_exp) m_err++;
    end
    #1;
  endtask

  task automatic drive(logic [2:0] f, logic [6:0] op, logic [4:0] d, logic [2:0] f3,
      logic [4:0] s1, logic [4:0] s2, logic [6:0] f7, logic [31:0] im);
    in_valid = 1; fmt = f; opcode = op; rd = d; funct3 = f3;
    rs1 = s1; rs2 = s2; funct7 = f7; imm = im;
  endtask

  task automatic drive_rand(bit legal_only);
    logic [2:0] f = legal_only ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7));
    logic [31:0] im = $urandom;
    logic [6:0] op = {5'($urandom), 2'b11};
    if (!legal_only && $urandom_range(0, 7) == 0) op = 7'($urandom);
    if (legal_only || $urandom_range(0, 3) != 0) im[0] = 1'b0;
    drive(f, op, 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 7'($urandom), im);
  endtask

  task automatic encode_one(string tag, logic [31:0] exp);
    cyc();
    in_valid = 0;
    check({tag, "_valid"}, out_valid, 1);
    check(tag, out_instr, exp);
    cyc();
  endtask

  initial begin
    cyc();
    cyc();
    rst = 0;
    chk_en = 1;
    cyc();
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);

    drive(0, 7'h33, 3, 0, 1, 2, 0, 0);
    cyc();
    in_valid = 0;
    check("R_instr", out_instr, 32'h002081B3);
    check("R_count", enc_count, 1);
    cyc();
    drive(1, 7'h13, 1, 0, 0, 0, 0, 32'hFFFFFFFF);
    encode_one("I_instr", 32'hFFF00093);
    drive(2, 7'h23, 0, 2, 1, 2, 0, 8);
    encode_one("S_instr", 32'h0020A423);
    drive(4, 7'h37, 5, 0, 0, 0, 0, 32'h12345000);
    encode_one("U_instr", 32'h123452B7);
    drive(5, 7'h6F, 1, 0, 0, 0, 0, 32'h800);
    encode_one("J_instr", 32'h001000EF);

    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive_rand(1);
      cyc();
    end
    cyc();
    check("bp_in_ready", in_ready, 0);
    check("bp_count", enc_count, 7);
    out_ready = 1;
    for (int i = 0; i < 6 && in_valid; i++) begin
      cyc();
      if (last_acc) in_valid = 0;
    end
    check("bp_third_accepted", in_valid, 0);
    cyc();
    cyc();
    cyc();
    check("bp_final_count", enc_count, 8);

    drive(3, 7'h63, 0, 0, 1, 2, 0, 5);
    cyc();
    in_valid = 0;
    check("illegal_B_err", err, 1);
    check("illegal_B_cnt", err_count, 1);
    check("illegal_B_novalid", out_valid, 0);
    cyc();
    check("err_one_cycle", err, 0);
    drive(7, 7'h33, 0, 0, 0, 0, 0, 0);
    cyc();
    in_valid = 0;
    cyc();
    check("illegal_fmt_cnt", err_count, 2);
    drive(0, 7'h30, 0, 0, 0, 0, 0, 0);
    cyc();
    in_valid = 0;
    cyc();
    check("illegal_op_cnt", err_count, 3);

    drive_rand(1);
    cyc();
    for (int i = 0; i < 10; i++) begin
      drive_rand(1);
      cyc();
      check("pp_no_stall", last_acc, 1);
    end
    in_valid = 0;
    cyc();
    cyc();

    for (int i = 0; i < 400; i++) begin
      out_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 3) != 0) drive_rand(0);
      else in_valid = 0;
      cyc();
    end

    out_ready = 0;
    in_valid = 0;
    cyc();
    drive_rand(1);
    cyc();
    cyc();
    check("pre_rst_full", in_ready, 0);
    rst = 1;
    cyc();
    rst = 0;
    in_valid = 0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_enc_count", enc_count, 0);
    check("rst_err_count", err_count, 0);
    out_ready = 1;
    drive(1, 7'h13, 1, 0, 0, 0, 0, 32'hFFFFFFFF);
    encode_one("post_rst_instr", 32'hFFF00093);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
